riscv_alu_mc: RTL and testbench
===============================

Name: riscv_alu_mc

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Adds full RV32M/RV64M multiply-high and divide/remainder, plus valid/ready flow control on both sides and a registered result.
- Sits in the execute stage; the pipeline stalls on alu_ready_o/alu_valid_o while an iterative divide is in flight.

Parameters:
- XLEN, 32, operand/result width; power of two, 8 to 64; shift amount = b[$clog2(XLEN)-1:0].

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- alu_valid_i  in  1  operation request valid
- alu_ready_o  out  1  block can accept an operation this cycle
- alu_op_i  in  5  operation code (below)
- alu_a_i  in  XLEN  operand A (rs1)
- alu_b_i  in  XLEN  operand B (rs2/imm)
- alu_valid_o  out  1  result valid
- alu_ready_i  in  1  consumer accepts result
- alu_p_o  out  XLEN  registered result

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous, active-high.
- Op codes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLL, 00110 SRL, 00111 SRA, 01000 SLT, 01001 SLTU, 01010 MUL(low)
  - 01011 MULH, 01100 MULHSU (A signed, B unsigned), 01101 MULHU
  - 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU
  - All other codes: result 0.
- Reset, while rst_i high and after: state IDLE, alu_valid_o=0, alu_p_o=0, divider counter/registers=0, alu_ready_o=0 while rst_i high.
- FSM states IDLE, DIV, DONE.
- alu_ready_o = ~rst_i & (state==IDLE | (state==DONE & alu_ready_i)).
- Accept = alu_valid_i & alu_ready_o at a rising edge. Operands and op are captured only on accept.
- Non-divide op, or divide special case: result computed combinationally, registered at accept; go to DONE. alu_valid_o is high in the cycle after accept (latency 1).
- Divide op, normal case: go to DIV. Radix-2 restoring divide on |A|, |B|, one quotient bit per cycle, XLEN cycles. Then sign-correct:
  - quotient negated iff operand signs differ (signed ops);
  - remainder takes the sign of A.
  - Then DONE. alu_valid_o rises XLEN+1 cycles after accept.
- Divide special cases complete in 1 cycle:
  - B==0: DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow (A = most-negative, B = -1): DIV returns A; REM returns 0.
- DONE: alu_valid_o=1. alu_p_o is held stable until alu_ready_i.
  - On alu_ready_i with no new accept: go to IDLE, alu_valid_o=0.
  - Accept in the same cycle: take the new op's path. Back-to-back single-cycle ops therefore sustain 1 op/cycle.
- During DIV: alu_ready_o=0, alu_valid_o=0. Input changes are ignored.
- Widths:
  - MUL* uses a 2*XLEN product. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - SLT/SLTU return 1 or 0, zero-extended.
  - SRA is arithmetic; SRL/SLL are logical.
- rst_i asserted mid-DIV or in DONE: abort; next cycle is IDLE with all outputs at reset values. No result is produced for the aborted op.

Optional Feature:
- Macro RISCV_ALU_DIV_EN.
- Defined: divider datapath, DIV state and codes 01110-10001 are implemented as above.
- Undefined: no divider logic, no DIV state. Codes 01110-10001 behave as unknown codes: result 0, latency 1.

Test Plan:
- ADD 0x7FFFFFFF+1, then SRA 0x80000000 by 4, on back-to-back cycles with alu_ready_i=1 -> alu_p_o 0x80000000 then 0xF8000000 on consecutive cycles; alu_ready_o stays 1.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 3*-2 -> 0xFFFFFFFA.
- DIV -7/2 -> 0xFFFFFFFD, and REM -7%2 -> 0xFFFFFFFF. alu_valid_o rises exactly 33 cycles after accept; alu_ready_o low throughout DIV.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each with latency 1.
- Backpressure: hold alu_ready_i=0 for 3 cycles after an XOR 0xF0F0F0F0^0xFFFF0000 -> alu_p_o stays 0x0F0FF0F0, alu_valid_o=1, alu_ready_o=0, until alu_ready_i rises.
- Assert rst_i 10 cycles into DIVU 100/7 -> next cycle alu_valid_o=0, alu_p_o=0, state IDLE. After reset, DIVU 100/7 -> 14 and REMU -> 2.

Source files
------------

// File: rtl/riscv_alu_mc.sv
// Handshaked RV32/RV64 IM ALU with a registered result. The iterative radix-2 divider
// and its DIV state are only built when RISCV_ALU_DIV_EN is defined.
module riscv_alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] alu_a_i,
    input  logic [XLEN-1:0] alu_b_i,
    output logic            alu_valid_o,
    input  logic            alu_ready_i,
    output logic [XLEN-1:0] alu_p_o
);

    // state | meaning
    // IDLE  | no result held, ready for an op
    // DIV   | iterative divide in flight, inputs ignored
    // DONE  | result valid on alu_p_o until consumer takes it
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLL    = 5'b00101;
    localparam logic [4:0] OP_SRL    = 5'b00110;
    localparam logic [4:0] OP_SRA    = 5'b00111;
    localparam logic [4:0] OP_SLT    = 5'b01000;
    localparam logic [4:0] OP_SLTU   = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;

`ifdef RISCV_ALU_DIV_EN
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t            state_q;
    logic              valid_q;
    logic [XLEN-1:0]   p_q;
    logic              accept;
    logic [XLEN-1:0]   fast_res;
    logic [SHW-1:0]    shamt;
    logic              mul_sa;
    logic              mul_sb;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;

    assign alu_ready_o = ~rst_i & ((state_q == S_IDLE) | ((state_q == S_DONE) & alu_ready_i));
    assign accept      = alu_valid_i & alu_ready_o;
    assign alu_valid_o = valid_q;
    assign alu_p_o     = p_q;

    // One 2*XLEN multiplier; operand extension picks signed/unsigned high half.
    assign shamt  = alu_b_i[SHW-1:0];
    assign mul_sa = (alu_op_i == OP_MULH) || (alu_op_i == OP_MULHSU);
    assign mul_sb = (alu_op_i == OP_MULH);
    assign mul_a  = {{XLEN{mul_sa & alu_a_i[XLEN-1]}}, alu_a_i};
    assign mul_b  = {{XLEN{mul_sb & alu_b_i[XLEN-1]}}, alu_b_i};
    assign prod   = mul_a * mul_b;

`ifdef RISCV_ALU_DIV_EN
    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic            div_op;
    logic            div_sgn;
    logic            div_rem;
    logic            a_neg;
    logic            b_neg;
    logic            div_spec;
    logic            start_div;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] div_res;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            is_rem_q;

    always_comb begin
        div_op    = alu_op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        div_sgn   = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
        div_rem   = (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
        a_neg     = div_sgn & alu_a_i[XLEN-1];
        b_neg     = div_sgn & alu_b_i[XLEN-1];
        a_abs     = a_neg ? -alu_a_i : alu_a_i;
        b_abs     = b_neg ? -alu_b_i : alu_b_i;
        div_spec  = 1'b0;
        spec_res  = '0;
        if (alu_b_i == '0) begin
            div_spec = 1'b1;
            spec_res = div_rem ? alu_a_i : '1;
        end else if (div_sgn && (alu_a_i == MOST_NEG) && (alu_b_i == '1)) begin
            div_spec = 1'b1;
            spec_res = div_rem ? '0 : alu_a_i;
        end
        start_div = div_op & ~div_spec;
    end

    // Restoring step: shift the next dividend bit into the partial remainder.
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvsr_q};
    assign div_res = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quo_q ? -quo_q : quo_q);
`endif

    always_comb begin
        fast_res = '0;
        case (alu_op_i)
            OP_ADD:    fast_res = alu_a_i + alu_b_i;
            OP_SUB:    fast_res = alu_a_i - alu_b_i;
            OP_AND:    fast_res = alu_a_i & alu_b_i;
            OP_OR:     fast_res = alu_a_i | alu_b_i;
            OP_XOR:    fast_res = alu_a_i ^ alu_b_i;
            OP_SLL:    fast_res = alu_a_i << shamt;
            OP_SRL:    fast_res = alu_a_i >> shamt;
            OP_SRA:    fast_res = $signed(alu_a_i) >>> shamt;
            OP_SLT:    fast_res = {{(XLEN-1){1'b0}}, $signed(alu_a_i) < $signed(alu_b_i)};
            OP_SLTU:   fast_res = {{(XLEN-1){1'b0}}, alu_a_i < alu_b_i};
            OP_MUL:    fast_res = prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fast_res = prod[2*XLEN-1:XLEN];
            default:   fast_res = '0;
        endcase
`ifdef RISCV_ALU_DIV_EN
        if (div_op) fast_res = spec_res;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            p_q       <= '0;
`ifdef RISCV_ALU_DIV_EN
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
`ifdef RISCV_ALU_DIV_EN
                        if (start_div) begin
                            state_q   <= S_DIV;
                            valid_q   <= 1'b0;
                            cnt_q     <= CW'(XLEN);
                            rem_q     <= '0;
                            quo_q     <= a_abs;
                            dvsr_q    <= b_abs;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            is_rem_q  <= div_rem;
                        end else begin
`endif
                            state_q <= S_DONE;
                            valid_q <= 1'b1;
                            p_q     <= fast_res;
`ifdef RISCV_ALU_DIV_EN
                        end
`endif
                    end else if ((state_q == S_DONE) && alu_ready_i) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
`ifdef RISCV_ALU_DIV_EN
                S_DIV: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                        rem_q <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
                    end else begin
                        state_q <= S_DONE;
                        valid_q <= 1'b1;
                        p_q     <= div_res;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_alu_mc.sv
// Bench for riscv_alu_mc (XLEN=32): cycle-level reference model plus directed vectors.
// Divide expectations follow RISCV_ALU_DIV_EN the same way the design does.
module tb_riscv_alu_mc;

`ifdef RISCV_ALU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int DLAT = DIV_ON ? 33 : 1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_op_i;
    logic [31:0] alu_a_i;
    logic [31:0] alu_b_i;
    logic        alu_valid_o;
    logic        alu_ready_i;
    logic [31:0] alu_p_o;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    riscv_alu_mc #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_op_i    (alu_op_i),
        .alu_a_i     (alu_a_i),
        .alu_b_i     (alu_b_i),
        .alu_valid_o (alu_valid_o),
        .alu_ready_i (alu_ready_i),
        .alu_p_o     (alu_p_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: results straight from the ISA arithmetic definitions.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic        [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  return $signed(a) >>> b[4:0];
            5'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd10: begin p = sa * sb; return p[31:0]; end
            5'd11: begin p = sa * sb; return p[63:32]; end
            5'd12: begin p = sa * ub; return p[63:32]; end
            5'd13: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            5'd14: begin
                if (!DIV_ON) return 32'd0;
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            5'd15: begin
                if (!DIV_ON) return 32'd0;
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            5'd16: begin
                if (!DIV_ON) return 32'd0;
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            5'd17: begin
                if (!DIV_ON) return 32'd0;
                if (b == 0) return a;
                return a % b;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit long_div(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
        if (!DIV_ON) return 1'b0;
        if (!(op inside {5'd14, 5'd15, 5'd16, 5'd17})) return 1'b0;
        if (b == 0) return 1'b0;
        if ((op == 5'd14 || op == 5'd16) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1'b0;
        return 1'b1;
    endfunction

    // Model state: result held, pending divide countdown, whether alu_p_o is defined.
    bit          m_valid = 1'b0;
    int          m_busy  = 0;
    logic [31:0] m_p     = '0;
    logic [31:0] m_pend  = '0;
    bit          m_pchk  = 1'b0;

    function automatic bit exp_ready();
        return !rst_i && ((!m_valid && m_busy == 0) || (m_valid && alu_ready_i));
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            m_valid <= 1'b0;
            m_busy  <= 0;
            m_p     <= '0;
            m_pchk  <= 1'b1;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_valid <= 1'b1;
                m_p     <= m_pend;
                m_pchk  <= 1'b1;
            end
        end else if (alu_valid_i && exp_ready()) begin
            if (long_div(alu_op_i, alu_a_i, alu_b_i)) begin
                m_busy  <= 33;
                m_valid <= 1'b0;
                m_pend  <= ref_alu(alu_op_i, alu_a_i, alu_b_i);
                m_pchk  <= 1'b0;
            end else begin
                m_valid <= 1'b1;
                m_p     <= ref_alu(alu_op_i, alu_a_i, alu_b_i);
                m_pchk  <= 1'b1;
            end
        end else if (m_valid && alu_ready_i) begin
            m_valid <= 1'b0;
            m_pchk  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model ready_o", {31'd0, alu_ready_o}, {31'd0, exp_ready()});
            check("model valid_o", {31'd0, alu_valid_o}, {31'd0, m_valid});
            if (m_pchk) check("model p_o", alu_p_o, m_p);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        alu_valid_i = 1'b1;
        alu_op_i    = op;
        alu_a_i     = a;
        alu_b_i     = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (alu_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL issue: ready_o never high for op %0d", op);
        end
        @(posedge clk);
        #1;
        alu_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp, input int exp_lat);
        int lat;
        int rdy_hi;
        lat    = 0;
        rdy_hi = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (alu_valid_o === 1'b1) begin
                lat = i;
                break;
            end
            if (alu_ready_o !== 1'b0) rdy_hi++;
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no result within 100 cycles", name);
        end else begin
            check({name, " result"}, alu_p_o, exp);
            check({name, " latency"}, lat, exp_lat);
            if (exp_lat > 1) check({name, " ready high while busy"}, rdy_hi, 0);
        end
    endtask

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input string n, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] e, input int l);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.exp = e; v.lat = l;
        vq.push_back(v);
    endfunction

    initial begin
        rst_i       = 1'b1;
        alu_valid_i = 1'b0;
        alu_ready_i = 1'b1;
        alu_op_i    = '0;
        alu_a_i     = '0;
        alu_b_i     = '0;

        add("SUB",      5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1);
        add("AND",      5'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1);
        add("OR",       5'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1);
        add("SLL",      5'd5,  32'd1,        32'h0000003F, 32'h80000000, 1);
        add("SRL",      5'd6,  32'h80000000, 32'd4,        32'h08000000, 1);
        add("SLT",      5'd8,  32'hFFFFFFFF, 32'd1,        32'd1,        1);
        add("SLTU",     5'd9,  32'hFFFFFFFF, 32'd1,        32'd0,        1);
        add("MULH",     5'd11, 32'h80000000, 32'h80000000, 32'h40000000, 1);
        add("MULHU",    5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        add("MULHSU",   5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        add("MUL",      5'd10, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFA, 1);
        add("DIV -7/2", 5'd14, 32'hFFFFFFF9, 32'd2,        DIV_ON ? 32'hFFFFFFFD : 32'd0, DLAT);
        add("REM -7%2", 5'd16, 32'hFFFFFFF9, 32'd2,        DIV_ON ? 32'hFFFFFFFF : 32'd0, DLAT);
        add("DIV 7/-2", 5'd14, 32'd7,        32'hFFFFFFFE, DIV_ON ? 32'hFFFFFFFD : 32'd0, DLAT);
        add("REM 7%-2", 5'd16, 32'd7,        32'hFFFFFFFE, DIV_ON ? 32'd1 : 32'd0,        DLAT);
        add("DIVU 5/0", 5'd15, 32'd5,        32'd0,        DIV_ON ? 32'hFFFFFFFF : 32'd0, 1);
        add("REMU 5/0", 5'd17, 32'd5,        32'd0,        DIV_ON ? 32'd5 : 32'd0,        1);
        add("DIV ovf",  5'd14, 32'h80000000, 32'hFFFFFFFF, DIV_ON ? 32'h80000000 : 32'd0, 1);
        add("REM ovf",  5'd16, 32'h80000000, 32'hFFFFFFFF, 32'd0,                         1);
        add("OP 10010", 5'd18, 32'd9,        32'd3,        32'd0,                         1);
        add("OP 11111", 5'd31, 32'hFFFFFFFF, 32'd1,        32'd0,                         1);

        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(negedge clk);
        check("reset valid_o", {31'd0, alu_valid_o}, 32'd0);
        check("reset p_o", alu_p_o, 32'd0);
        check("reset ready_o", {31'd0, alu_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("idle ready_o", {31'd0, alu_ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back ADD then SRA with the consumer always ready.
        alu_valid_i = 1'b1;
        alu_op_i = 5'd0; alu_a_i = 32'h7FFFFFFF; alu_b_i = 32'd1;
        @(posedge clk);
        #1;
        alu_op_i = 5'd7; alu_a_i = 32'h80000000; alu_b_i = 32'd4;
        @(negedge clk);
        check("b2b ADD p_o", alu_p_o, 32'h80000000);
        check("b2b ADD valid_o", {31'd0, alu_valid_o}, 32'd1);
        check("b2b ready_o", {31'd0, alu_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        alu_valid_i = 1'b0;
        @(negedge clk);
        check("b2b SRA p_o", alu_p_o, 32'hF8000000);
        check("b2b SRA valid_o", {31'd0, alu_valid_o}, 32'd1);
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            issue(vq[i].op, vq[i].a, vq[i].b);
            wait_result(vq[i].name, vq[i].exp, vq[i].lat);
            @(posedge clk);
            #1;
        end

        // Consumer stall: result must hold for three cycles.
        alu_ready_i = 1'b0;
        issue(5'd4, 32'hF0F0F0F0, 32'hFFFF0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall p_o", alu_p_o, 32'h0F0FF0F0);
            check("stall valid_o", {31'd0, alu_valid_o}, 32'd1);
            check("stall ready_o", {31'd0, alu_ready_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        alu_ready_i = 1'b1;
        @(negedge clk);
        check("release ready_o", {31'd0, alu_ready_o}, 32'd1);
        check("release p_o", alu_p_o, 32'h0F0FF0F0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release valid_o", {31'd0, alu_valid_o}, 32'd0);
        @(posedge clk);
        #1;

        // Reset ten cycles into a divide aborts it.
        issue(5'd15, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("abort valid_o", {31'd0, alu_valid_o}, 32'd0);
        check("abort p_o", alu_p_o, 32'd0);
        check("abort ready_o", {31'd0, alu_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        issue(5'd15, 32'd100, 32'd7);
        wait_result("DIVU 100/7", DIV_ON ? 32'd14 : 32'd0, DLAT);
        @(posedge clk);
        #1;
        issue(5'd17, 32'd100, 32'd7);
        wait_result("REMU 100%7", DIV_ON ? 32'd2 : 32'd0, DLAT);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
